axi_rd_xbar: RTL and testbench

- 1-to-2 AXI-lite read crossbar between the read arbiter's master side and the memory/device targets.
- Decodes each AR address and routes it to target 0 (SRAM/memory) or target 1 (MMIO devices: UART, CLINT).
- Unmapped addresses get a locally generated DECERR response.
- One outstanding read at a time; the write path is handled by a separate block.

---
 rtl/axi_rd_xbar_pkg.sv | 24 ++
 rtl/axi_rd_xbar_addr_decode.sv | 25 ++
 rtl/axi_rd_xbar.sv | 132 +++++++++++++
 tb/tb_axi_rd_xbar.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_xbar_pkg.sv
// Shared AXI-lite read-crossbar definitions: response codes, default address map
// and the one-hot FSM state encoding.
package axi_rd_xbar_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  localparam logic [31:0] MEM_BASE_DEF = 32'h8000_0000;
  localparam logic [31:0] MEM_MASK_DEF = 32'hF800_0000;
  localparam logic [31:0] DEV_BASE_DEF = 32'hA000_0000;
  localparam logic [31:0] DEV_MASK_DEF = 32'hF000_0000;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_REQ  = 4'b0010,
    ST_RSP  = 4'b0100,
    ST_ERR  = 4'b1000
  } xbar_state_t;

endpackage

// File: rtl/axi_rd_xbar_addr_decode.sv
// Combinational address decoder shared by the read and write crossbars.
// Memory wins over devices when both windows match.
module axi_addr_decode
  import axi_rd_xbar_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] MEM_BASE = ADDR_W'(MEM_BASE_DEF),
  parameter logic [ADDR_W-1:0] MEM_MASK = ADDR_W'(MEM_MASK_DEF),
  parameter logic [ADDR_W-1:0] DEV_BASE = ADDR_W'(DEV_BASE_DEF),
  parameter logic [ADDR_W-1:0] DEV_MASK = ADDR_W'(DEV_MASK_DEF)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [1:0]        hit,
  output logic              miss
);

  logic mem_match_s;
  logic dev_match_s;

  assign mem_match_s = ((addr & MEM_MASK) == MEM_BASE);
  assign dev_match_s = ((addr & DEV_MASK) == DEV_BASE);
  assign hit         = {dev_match_s & ~mem_match_s, mem_match_s};
  assign miss        = ~(mem_match_s | dev_match_s);

endmodule

// File: rtl/axi_rd_xbar.sv
// 1-to-2 AXI-lite read crossbar (memory / MMIO) with local DECERR for unmapped
// addresses; a single read is in flight at any time.
module axi_rd_xbar
  import axi_rd_xbar_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] MEM_BASE = ADDR_W'(MEM_BASE_DEF),
  parameter logic [ADDR_W-1:0] MEM_MASK = ADDR_W'(MEM_MASK_DEF),
  parameter logic [ADDR_W-1:0] DEV_BASE = ADDR_W'(DEV_BASE_DEF),
  parameter logic [ADDR_W-1:0] DEV_MASK = ADDR_W'(DEV_MASK_DEF)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                slv_ar_valid_i,
  input  logic [ADDR_W-1:0]   slv_ar_addr_i,
  output logic                slv_ar_ready_o,
  output logic                slv_r_valid_o,
  output logic [DATA_W-1:0]   slv_r_data_o,
  output logic [1:0]          slv_r_resp_o,
  input  logic                slv_r_ready_i,
  output logic [1:0]          m_ar_valid_o,
  output logic [2*ADDR_W-1:0] m_ar_addr_o,
  input  logic [1:0]          m_ar_ready_i,
  input  logic [1:0]          m_r_valid_i,
  input  logic [2*DATA_W-1:0] m_r_data_i,
  input  logic [3:0]          m_r_resp_i,
  output logic [1:0]          m_r_ready_o
);

  xbar_state_t       state_r;
  xbar_state_t       state_nxt_s;
  logic              sel_r;
  logic [ADDR_W-1:0] addr_q_r;
  logic [1:0]        hit_s;
  logic              miss_s;
  logic              ar_hs_s;

  axi_addr_decode #(
    .ADDR_W   (ADDR_W),
    .MEM_BASE (MEM_BASE),
    .MEM_MASK (MEM_MASK),
    .DEV_BASE (DEV_BASE),
    .DEV_MASK (DEV_MASK)
  ) u_decode (
    .addr (slv_ar_addr_i),
    .hit  (hit_s),
    .miss (miss_s)
  );

  assign ar_hs_s = (state_r == ST_IDLE) && slv_ar_valid_i;

  // State register plus the address/target captured when an AR is accepted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r  <= ST_IDLE;
      sel_r    <= 1'b0;
      addr_q_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (ar_hs_s) begin
        addr_q_r <= slv_ar_addr_i;
        sel_r    <= hit_s[1];
      end else begin
        addr_q_r <= addr_q_r;
        sel_r    <= sel_r;
      end
    end
  end

  // Both slices carry the latched address; only the valid bit selects the target.
  assign m_ar_addr_o = {addr_q_r, addr_q_r};

  // Next-state and handshake outputs; the R path is a straight pass-through in RSP.
  always_comb begin
    state_nxt_s    = state_r;
    slv_ar_ready_o = 1'b0;
    slv_r_valid_o  = 1'b0;
    slv_r_data_o   = '0;
    slv_r_resp_o   = OKAY;
    m_ar_valid_o   = 2'b00;
    m_r_ready_o    = 2'b00;
    case (state_r)
      ST_IDLE: begin
        slv_ar_ready_o = ~rst_i;
        if (slv_ar_valid_i) begin
          if (miss_s) begin
            state_nxt_s = ST_ERR;
          end else if (hit_s[0] | hit_s[1]) begin
            state_nxt_s = ST_REQ;
          end else begin
            state_nxt_s = ST_ERR;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        m_ar_valid_o[sel_r] = 1'b1;
        if (m_ar_ready_i[sel_r]) begin
          state_nxt_s = ST_RSP;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_RSP: begin
        slv_r_valid_o      = m_r_valid_i[sel_r];
        slv_r_data_o       = sel_r ? m_r_data_i[2*DATA_W-1:DATA_W] : m_r_data_i[DATA_W-1:0];
        slv_r_resp_o       = sel_r ? m_r_resp_i[3:2] : m_r_resp_i[1:0];
        m_r_ready_o[sel_r] = slv_r_ready_i;
        if (m_r_valid_i[sel_r] && slv_r_ready_i) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RSP;
        end
      end
      ST_ERR: begin
        slv_r_valid_o = 1'b1;
        slv_r_resp_o  = DECERR;
        if (slv_r_ready_i) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ERR;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_axi_rd_xbar.sv
// Bench for axi_rd_xbar: directed scenarios with literal expectations, then random
// traffic compared every cycle against a transaction-level model.
module tb_axi_rd_xbar;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        slv_ar_valid_i;
  logic [31:0] slv_ar_addr_i;
  logic        slv_ar_ready_o;
  logic        slv_r_valid_o;
  logic [31:0] slv_r_data_o;
  logic [1:0]  slv_r_resp_o;
  logic        slv_r_ready_i;
  logic [1:0]  m_ar_valid_o;
  logic [63:0] m_ar_addr_o;
  logic [1:0]  m_ar_ready_i;
  logic [1:0]  m_r_valid_i;
  logic [63:0] m_r_data_i;
  logic [3:0]  m_r_resp_i;
  logic [1:0]  m_r_ready_o;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: whether a read is open, its destination (0 mem, 1 dev, 2 error) and
  // whether the downstream address phase has completed.
  bit          mdl_busy = 1'b0;
  int          mdl_kind = 0;
  bit          mdl_ar_done = 1'b0;
  logic [31:0] mdl_addr = 32'h0;

  axi_rd_xbar dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .slv_ar_valid_i (slv_ar_valid_i),
    .slv_ar_addr_i  (slv_ar_addr_i),
    .slv_ar_ready_o (slv_ar_ready_o),
    .slv_r_valid_o  (slv_r_valid_o),
    .slv_r_data_o   (slv_r_data_o),
    .slv_r_resp_o   (slv_r_resp_o),
    .slv_r_ready_i  (slv_r_ready_i),
    .m_ar_valid_o   (m_ar_valid_o),
    .m_ar_addr_o    (m_ar_addr_o),
    .m_ar_ready_i   (m_ar_ready_i),
    .m_r_valid_i    (m_r_valid_i),
    .m_r_data_i     (m_r_data_i),
    .m_r_resp_i     (m_r_resp_i),
    .m_r_ready_o    (m_r_ready_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic int ref_decode(input logic [31:0] a);
    if ((a & 32'hF800_0000) == 32'h8000_0000) return 0;
    if ((a & 32'hF000_0000) == 32'hA000_0000) return 1;
    return 2;
  endfunction

  // Per-cycle comparison against the model, then advance the model by one clock.
  always @(negedge clk_i) begin : cmp
    logic [1:0] e_arv;
    logic [1:0] e_rr;
    logic       e_rv;
    logic       e_arr;
    if (chk_en) begin
      if (rst_i) mdl_busy = 1'b0;
      e_arr = !mdl_busy && !rst_i;
      e_arv = 2'b00;
      e_rr  = 2'b00;
      e_rv  = 1'b0;
      if (mdl_busy) begin
        if (mdl_kind == 2) begin
          e_rv = 1'b1;
        end else if (!mdl_ar_done) begin
          e_arv[mdl_kind] = 1'b1;
        end else begin
          e_rv = m_r_valid_i[mdl_kind];
          e_rr[mdl_kind] = slv_r_ready_i;
        end
      end
      chk("cyc_ar_ready", {63'h0, slv_ar_ready_o}, {63'h0, e_arr});
      chk("cyc_m_ar_valid", {62'h0, m_ar_valid_o}, {62'h0, e_arv});
      chk("cyc_m_r_ready", {62'h0, m_r_ready_o}, {62'h0, e_rr});
      chk("cyc_r_valid", {63'h0, slv_r_valid_o}, {63'h0, e_rv});
      if (e_arv != 2'b00)
        chk("cyc_ar_addr", {32'h0, m_ar_addr_o[mdl_kind*32 +: 32]}, {32'h0, mdl_addr});
      if (e_rv) begin
        if (mdl_kind == 2) begin
          chk("cyc_r_data", {32'h0, slv_r_data_o}, 64'h0);
          chk("cyc_r_resp", {62'h0, slv_r_resp_o}, 64'h3);
        end else begin
          chk("cyc_r_data", {32'h0, slv_r_data_o}, {32'h0, m_r_data_i[mdl_kind*32 +: 32]});
          chk("cyc_r_resp", {62'h0, slv_r_resp_o}, {62'h0, m_r_resp_i[mdl_kind*2 +: 2]});
        end
      end
      if (rst_i) begin
        mdl_busy = 1'b0;
      end else if (!mdl_busy) begin
        if (slv_ar_valid_i) begin
          mdl_busy    = 1'b1;
          mdl_kind    = ref_decode(slv_ar_addr_i);
          mdl_ar_done = 1'b0;
          mdl_addr    = slv_ar_addr_i;
        end
      end else if (mdl_kind < 2 && !mdl_ar_done) begin
        if (m_ar_ready_i[mdl_kind]) mdl_ar_done = 1'b1;
      end else if (e_rv && slv_r_ready_i) begin
        mdl_busy = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    slv_ar_valid_i = 1'b0;
    slv_ar_addr_i  = 32'h0;
    slv_r_ready_i  = 1'b0;
    m_ar_ready_i   = 2'b00;
    m_r_valid_i    = 2'b00;
    m_r_data_i     = 64'h0;
    m_r_resp_i     = 4'h0;
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] bnd [8];
    bnd = '{32'h8000_0000, 32'h87FF_FFFC, 32'h8800_0000, 32'h7FFF_FFFC,
            32'h9FFF_FFFC, 32'hA000_0000, 32'hAFFF_FFFC, 32'hB000_0000};
    case ($urandom_range(3))
      0:       return 32'h8000_0000 | ($urandom() & 32'h07FF_FFFF);
      1:       return 32'hA000_0000 | ($urandom() & 32'h0FFF_FFFF);
      2:       return $urandom();
      default: return bnd[$urandom_range(7)];
    endcase
  endfunction

  initial begin
    idle_inputs();
    repeat (3) tick();
    smp();
    chk("rst_ar_ready", {63'h0, slv_ar_ready_o}, 64'h0);
    chk("rst_m_ar_valid", {62'h0, m_ar_valid_o}, 64'h0);
    chk("rst_r_valid", {63'h0, slv_r_valid_o}, 64'h0);
    chk("rst_r_data", {32'h0, slv_r_data_o}, 64'h0);
    chk("rst_r_resp", {62'h0, slv_r_resp_o}, 64'h0);
    chk("rst_m_r_ready", {62'h0, m_r_ready_o}, 64'h0);
    chk("rst_m_ar_addr", m_ar_addr_o, 64'h0);
    tick();
    rst_i  = 1'b0;
    chk_en = 1'b1;

    // Memory read: target 0 takes its AR on cycle 3.
    tick(); slv_ar_valid_i = 1'b1; slv_ar_addr_i = 32'h8000_1000;
    smp(); chk("mem_ar_ready", {63'h0, slv_ar_ready_o}, 64'h1);
    tick(); slv_ar_valid_i = 1'b0;
    smp(); chk("mem_arv_c1", {62'h0, m_ar_valid_o}, 64'h1);
    chk("mem_addr0", {32'h0, m_ar_addr_o[31:0]}, 64'h8000_1000);
    tick(); smp(); chk("mem_arv_c2", {62'h0, m_ar_valid_o}, 64'h1);
    tick(); m_ar_ready_i = 2'b01;
    smp(); chk("mem_arv_c3", {62'h0, m_ar_valid_o}, 64'h1);
    tick(); m_ar_ready_i = 2'b00; m_r_valid_i = 2'b01; m_r_data_i = 64'h0000_0000_DEAD_BEEF;
    slv_r_ready_i = 1'b1;
    smp(); chk("mem_r_valid", {63'h0, slv_r_valid_o}, 64'h1);
    chk("mem_r_data", {32'h0, slv_r_data_o}, 64'hDEAD_BEEF);
    chk("mem_r_resp", {62'h0, slv_r_resp_o}, 64'h0);
    chk("mem_m_r_ready", {62'h0, m_r_ready_o}, 64'h1);
    tick(); idle_inputs();
    smp(); chk("mem_back_idle", {63'h0, slv_ar_ready_o}, 64'h1);

    // Device read.
    tick(); slv_ar_valid_i = 1'b1; slv_ar_addr_i = 32'hA000_03F8;
    tick(); slv_ar_valid_i = 1'b0; m_ar_ready_i = 2'b10;
    smp(); chk("dev_arv", {62'h0, m_ar_valid_o}, 64'h2);
    chk("dev_addr1", {32'h0, m_ar_addr_o[63:32]}, 64'hA000_03F8);
    tick(); m_ar_ready_i = 2'b00; m_r_valid_i = 2'b10; m_r_data_i = 64'h0000_0041_FFFF_FFFF;
    slv_r_ready_i = 1'b1;
    smp(); chk("dev_r_data", {32'h0, slv_r_data_o}, 64'h41);
    chk("dev_m_r_ready", {62'h0, m_r_ready_o}, 64'h2);
    tick(); idle_inputs();

    // Unmapped read with the response stalled for three cycles.
    tick(); slv_ar_valid_i = 1'b1; slv_ar_addr_i = 32'h0000_0000;
    tick(); slv_ar_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("err_r_valid", {63'h0, slv_r_valid_o}, 64'h1);
      chk("err_r_resp", {62'h0, slv_r_resp_o}, 64'h3);
      chk("err_r_data", {32'h0, slv_r_data_o}, 64'h0);
      chk("err_no_down", {60'h0, m_ar_valid_o, m_r_ready_o}, 64'h0);
      tick();
    end
    slv_r_ready_i = 1'b1;
    smp(); chk("err_r_valid_rdy", {63'h0, slv_r_valid_o}, 64'h1);
    tick(); idle_inputs();
    smp(); chk("err_back_idle", {63'h0, slv_ar_ready_o}, 64'h1);

    // Backpressure plus stray R from both targets.
    tick(); slv_ar_valid_i = 1'b1; slv_ar_addr_i = 32'h8000_0040;
    tick(); slv_ar_valid_i = 1'b0; m_ar_ready_i = 2'b01; m_r_valid_i = 2'b11;
    smp(); chk("bp_req_r_valid", {63'h0, slv_r_valid_o}, 64'h0);
    tick(); m_ar_ready_i = 2'b00; m_r_data_i = 64'hBAD0_BAD0_1234_5678; m_r_resp_i = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("bp_m_r_ready", {62'h0, m_r_ready_o}, 64'h0);
      chk("bp_r_data", {32'h0, slv_r_data_o}, 64'h1234_5678);
      chk("bp_r_resp", {62'h0, slv_r_resp_o}, 64'h0);
      tick();
    end
    slv_r_ready_i = 1'b1;
    smp(); chk("bp_m_r_ready_go", {62'h0, m_r_ready_o}, 64'h1);
    tick(); idle_inputs();
    smp(); chk("bp_done", {62'h0, slv_ar_ready_o, slv_r_valid_o}, 64'h2);

    // Back-to-back with AR valid held high.
    tick(); slv_ar_valid_i = 1'b1; slv_ar_addr_i = 32'h8000_0000; m_ar_ready_i = 2'b11;
    m_r_valid_i = 2'b11; slv_r_ready_i = 1'b1; m_r_data_i = 64'h0000_0222_0000_0111;
    tick(); slv_ar_addr_i = 32'hA000_0000;
    smp(); chk("b2b_c1_ar_ready", {63'h0, slv_ar_ready_o}, 64'h0);
    tick(); smp(); chk("b2b_r1_data", {31'h0, slv_r_valid_o, slv_r_data_o}, 64'h1_0000_0111);
    tick(); smp(); chk("b2b_c3_ar_ready", {63'h0, slv_ar_ready_o}, 64'h1);
    tick(); slv_ar_valid_i = 1'b0;
    smp(); chk("b2b_c4_arv", {62'h0, m_ar_valid_o}, 64'h2);
    tick(); smp(); chk("b2b_r2_data", {31'h0, slv_r_valid_o, slv_r_data_o}, 64'h1_0000_0222);
    tick(); idle_inputs();

    // Asynchronous reset while in REQ.
    tick(); slv_ar_valid_i = 1'b1; slv_ar_addr_i = 32'h8000_0100;
    tick(); slv_ar_valid_i = 1'b0;
    smp(); chk("rstm_arv_before", {62'h0, m_ar_valid_o}, 64'h1);
    #2 rst_i = 1'b1;
    #1 chk("rstm_arv_async", {62'h0, m_ar_valid_o}, 64'h0);
    chk("rstm_ar_ready_async", {63'h0, slv_ar_ready_o}, 64'h0);
    smp(); rst_i = 1'b0;
    tick(); slv_ar_valid_i = 1'b1; slv_ar_addr_i = 32'hA000_0010;
    smp(); chk("rstm_ar_ready_after", {63'h0, slv_ar_ready_o}, 64'h1);
    tick(); slv_ar_valid_i = 1'b0; m_ar_ready_i = 2'b10;
    tick(); m_ar_ready_i = 2'b00; m_r_valid_i = 2'b10; m_r_data_i = 64'h0000_0077_0000_0000;
    slv_r_ready_i = 1'b1;
    smp(); chk("rstm_new_data", {32'h0, slv_r_data_o}, 64'h77);
    tick(); idle_inputs();

    // Random traffic, with occasional reset pulses.
    for (int c = 0; c < 4000; c++) begin
      tick();
      rst_i          = ($urandom_range(99) == 0);
      slv_ar_valid_i = 1'($urandom_range(1));
      slv_ar_addr_i  = pick_addr();
      m_ar_ready_i   = 2'($urandom_range(3));
      m_r_valid_i    = 2'($urandom_range(3));
      m_r_data_i     = {$urandom(), $urandom()};
      m_r_resp_i     = 4'($urandom_range(15));
      slv_r_ready_i  = ($urandom_range(3) != 0);
    end
    tick(); rst_i = 1'b0; idle_inputs();
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
